serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first subtractor that computes `minuend - subtrahend - bin` one bit per clock using a single borrow flip-flop. It is the inverse datapath of the team's gate/RTL 1-bit adder: the same full-adder cell is reused with borrow in place of carry. Operands enter, and results leave, through valid/ready handshakes. It sits beside the adder test benches and its internal signals are inspected with `$show_all_signals`.

## Interface
- `WIDTH`, default 8. Operand and result width; legal range is 1 or more.
- `clk` input, 1 bit. Clock; all state changes on the rising edge.
- `rst_n` input, 1 bit. Reset is asynchronous and active-low.
- `in_valid` input, 1 bit. Operand set is valid.
- `in_ready` output, 1 bit. Block can accept operands. High only in IDLE.
- `minuend` input, WIDTH bits. Operand A.
- `subtrahend` input, WIDTH bits. Operand B.
- `bin` input, 1 bit. Borrow in.
- `out_valid` output, 1 bit. Result is valid. High only in DONE.
- `out_ready` input, 1 bit. Consumer accepts the result.
- `diff` output, WIDTH bits. Result, `(A - B - bin) mod 2^WIDTH`.
- `bout` output, 1 bit. Borrow out. Equals 1 iff `A < B + bin` (unsigned).
- `busy` output, 1 bit. High in SHIFT.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (asynchronous, `rst_n` low):
  - state goes to IDLE; `diff`=0; `bout`=0; borrow register=0; bit counter=0.
  - So during and after reset: `in_ready`=1, `out_valid`=0, `busy`=0.
- IDLE:
  - On `in_valid & in_ready`, capture A, B and `bin` into shift/borrow registers, clear the counter, go to SHIFT.
  - `in_valid` without acceptance leaves all state unchanged.
- SHIFT, once per cycle, with `a`=A[0], `b`=B[0], `br`=borrow:
  - `d = a ^ b ^ br`
  - `br_next = (~a & b) | (~(a ^ b) & br)`
  - Shift `d` into the result register at the MSB (right shift).
  - Right-shift A and B.
  - Increment the counter.
  - On the cycle where the counter reaches WIDTH-1, go to DONE. The result register then holds the full difference and borrow holds `bout`.
- DONE:
  - `diff`/`bout` are driven from registers and stay stable while `out_valid` is high and `out_ready` is low.
  - On `out_valid & out_ready`, go to IDLE. `diff`/`bout` keep their last values; they are not cleared.
- `in_valid` and the input operands are ignored outside IDLE. No queuing.
- `out_ready` is ignored outside DONE.
- Counter width is `$clog2(WIDTH+1)` bits. It never wraps within a transaction.
- WIDTH=1: SHIFT lasts exactly one cycle.

## Timing
- Let E be the input handshake edge.
  - SHIFT occupies edges E+1 through E+WIDTH.
  - `out_valid` is high after edge E+WIDTH (latency WIDTH cycles).
- With `out_ready` held high, the output handshake occurs at edge E+WIDTH+1 and `in_ready` is high after it.
  - Peak throughput is one operation per WIDTH+2 cycles.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- Reset asserted mid-SHIFT or mid-DONE:
  - Aborts immediately and asynchronously; the partial result is discarded.
  - `out_valid` drops without a handshake.
- Reset release is synchronous-safe: the first operand can be accepted at the first rising edge after `rst_n` is high.

## Test plan
- WIDTH=8. A=0x5A, B=0x3C, bin=0, `out_ready`=1 → `out_valid` exactly 8 cycles after accept; `diff`=0x1E, `bout`=0. `busy` high for 8 cycles.
- A=0x00, B=0x01, bin=0 → `diff`=0xFF, `bout`=1.
- A=0xFF, B=0xFF, bin=1 → `diff`=0xFF, `bout`=1.
- A=0x80, B=0x7F, bin=1 → `diff`=0x00, `bout`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `diff`/`bout` stable and `out_valid` stays high. Toggle `in_valid`/operands during SHIFT and DONE → no effect on the result, and `in_ready`=0 throughout.
- Reset: drop `rst_n` for 1 cycle at SHIFT cycle 4 → `out_valid`=0, `diff`=0, `bout`=0, `in_ready`=1. A new op A=0x10, B=0x01 then yields `diff`=0x0F, `bout`=0.
- Back-to-back: two ops with `in_valid` and `out_ready` held high → second accept exactly WIDTH+2 cycles after the first. Repeat for WIDTH=1: A=0, B=1, bin=0 → `diff`=1, `bout`=1.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial LSB-first subtractor (A - B - bin) with one borrow
//            flip-flop and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CNT_W-1:0] count;

    logic             bit_a;
    logic             bit_b;
    logic             d_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;

    // Full-adder cell with borrow in place of carry.
    always_comb begin
        bit_a       = a_sh[0];
        bit_b       = b_sh[0];
        d_bit       = bit_a ^ bit_b ^ borrow;
        borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
        res_next    = res_sh >> 1;
        res_next[WIDTH-1] = d_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            borrow    <= 1'b0;
            count     <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= minuend;
                        b_sh     <= subtrahend;
                        borrow   <= bin;
                        res_sh   <= '0;
                        count    <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= borrow_next;
                    count  <= count + CNT_W'(1);
                    // Outputs are loaded once so they hold steady through DONE and beyond.
                    if (count == LAST_BIT) begin
                        state     <= DONE;
                        diff      <= res_next;
                        bout      <= borrow_next;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
    logic [W-1:0] minuend, subtrahend, diff;

    logic         n1_in_valid, n1_in_ready, n1_bin, n1_out_valid, n1_out_ready, n1_bout, n1_busy;
    logic [0:0]   n1_minuend, n1_subtrahend, n1_diff;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .minuend(minuend), .subtrahend(subtrahend), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
        .bout(bout), .busy(busy)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
        .minuend(n1_minuend), .subtrahend(n1_subtrahend), .bin(n1_bin),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready), .diff(n1_diff),
        .bout(n1_bout), .busy(n1_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic logic [31:0] ref_diff(input int a, input int b, input int bi, input int w);
        return 32'((a - b - bi) & ((1 << w) - 1));
    endfunction

    function automatic logic [31:0] ref_bout(input int a, input int b, input int bi);
        return (a < b + bi) ? 32'd1 : 32'd0;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input int bp, input bit toggle);
        logic [31:0] ed, eb;
        int n, busy_cnt;
        bit seen_ready, unstable;
        ed = ref_diff(int'(a), int'(b), int'(bi), W);
        eb = ref_bout(int'(a), int'(b), int'(bi));
        minuend = a; subtrahend = b; bin = bi;
        in_valid = 1'b1;
        out_ready = (bp == 0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        n = 0; busy_cnt = 0; seen_ready = 1'b0;
        while (!out_valid && n < 3 * W) begin
            if (busy) busy_cnt++;
            if (in_ready) seen_ready = 1'b1;
            if (toggle) begin
                in_valid = 1'($urandom); minuend = W'($urandom);
                subtrahend = W'($urandom); bin = 1'($urandom);
            end
            tick;
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("busy_cycles", 32'(busy_cnt), 32'(W));
        check("in_ready_low_shift", 32'(seen_ready), 32'd0);
        check("diff", 32'(diff), ed);
        check("bout", 32'(bout), eb);
        if (bp > 0) begin
            unstable = 1'b0;
            for (int i = 0; i < bp; i++) begin
                if (toggle) begin
                    in_valid = 1'($urandom); minuend = W'($urandom);
                    subtrahend = W'($urandom); bin = 1'($urandom);
                end
                tick;
                if (!out_valid || in_ready || 32'(diff) != ed || 32'(bout) != eb) unstable = 1'b1;
            end
            check("backpressure_stable", 32'(unstable), 32'd0);
            out_ready = 1'b1;
        end
        tick;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("diff_held", 32'(diff), ed);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int t, acc, res, t_first, t_second;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        minuend = '0; subtrahend = '0; bin = 1'b0;
        n1_in_valid = 1'b0; n1_out_ready = 1'b0;
        n1_minuend = '0; n1_subtrahend = '0; n1_bin = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        tick;
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1, 0, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 5, 1'b1);

        // Reset in the middle of SHIFT cycle 4.
        minuend = 8'h5A; subtrahend = 8'h3C; bin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        tick;
        rst_n = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, 0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        exp_q.push_back(ref_diff(32'hC3, 32'h5D, 1, W) | (ref_bout(32'hC3, 32'h5D, 1) << 8));
        exp_q.push_back(ref_diff(32'h07, 32'h09, 0, W) | (ref_bout(32'h07, 32'h09, 0) << 8));
        minuend = 8'hC3; subtrahend = 8'h5D; bin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        t = 0; acc = 0; res = 0; t_first = -100; t_second = 0;
        while (res < 2 && t < 40) begin
            if (in_valid && in_ready) begin
                if (acc == 0) t_first = t; else t_second = t;
                acc++;
            end
            tick;
            t++;
            if (acc == 1) begin
                minuend = 8'h07; subtrahend = 8'h09; bin = 1'b0;
            end
            if (out_valid) begin
                check("b2b_result", {23'd0, bout, diff}, exp_q.pop_front());
                res++;
            end
        end
        in_valid = 1'b0;
        check("b2b_results_seen", 32'(res), 32'd2);
        check("b2b_spacing", 32'(t_second - t_first), 32'(W + 2));
        tick;
        out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        // WIDTH=1 instance: every operand combination.
        for (int k = 0; k < 8; k++) begin
            n1_minuend = 1'(k); n1_subtrahend = 1'(k >> 1); n1_bin = 1'(k >> 2);
            n1_in_valid = 1'b1; n1_out_ready = 1'b1;
            tick;
            n1_in_valid = 1'b0;
            check("w1_busy", 32'(n1_busy), 32'd1);
            check("w1_not_valid_yet", 32'(n1_out_valid), 32'd0);
            tick;
            check("w1_out_valid", 32'(n1_out_valid), 32'd1);
            check("w1_diff", 32'(n1_diff), ref_diff(k & 1, (k >> 1) & 1, (k >> 2) & 1, 1));
            check("w1_bout", 32'(n1_bout), ref_bout(k & 1, (k >> 1) & 1, (k >> 2) & 1));
            tick;
            check("w1_in_ready", 32'(n1_in_ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
